pip_issue_ctrl: RTL and testbench

- In-order issue controller in front of the 5-stage pipeline (IF/ID/EX/MEM/WB, 16x32 regfile).
- Accepts instructions from the fetch source over a valid/ready handshake and holds one in a skid register.
- Uses a per-register scoreboard to detect read-after-write hazards against in-flight instructions, and issues bubbles until each hazard clears.
- The pipeline has no forwarding and no internal stall, so this block alone guarantees correct operand reads.

---
 rtl/pip_isa_pkg.sv | 28 ++
 rtl/pip_scoreboard.sv | 41 ++++
 rtl/pip_issue_ctrl.sv | 117 +++++++++++
 tb/tb_pip_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pip_isa_pkg.sv
// ISA field layout, opcode constants and source-usage decode shared by the issue controller.
package pip_isa_pkg;

  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;

  localparam logic [FIELD_W-1:0] OP_NOP  = 4'h0;
  localparam logic [FIELD_W-1:0] OP_ADD  = 4'h1;
  localparam logic [FIELD_W-1:0] OP_SUB  = 4'h2;
  localparam logic [FIELD_W-1:0] OP_LOAD = 4'h3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } issue_state_t;

  function automatic logic uses_rs1(input logic [FIELD_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD);
  endfunction

  function automatic logic uses_rs2(input logic [FIELD_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/pip_scoreboard.sv
// Per-register busy down-counters; a load on the issue edge overrides that register's decrement.
module pip_scoreboard
  import pip_isa_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [FIELD_W-1:0] load_rd,
  input  logic [FIELD_W-1:0] load_val,
  input  logic [FIELD_W-1:0] rs1,
  input  logic [FIELD_W-1:0] rs2,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic               any_busy
);

  logic [NREG-1:0] nonzero;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
    logic [FIELD_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (load_en && (load_rd == FIELD_W'(gi))) begin
        cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end

    assign nonzero[gi] = |cnt_reg;
  end

  assign rs1_busy = nonzero[rs1];
  assign rs2_busy = nonzero[rs2];
  assign any_busy = |nonzero;

endmodule

// File: rtl/pip_issue_ctrl.sv
// In-order issue controller: skid hold register, RAW scoreboard interlock, registered issue port.
// Optional perf counters (perf_issued, perf_stalls) are built when ISSUE_PERF_EN is defined.
module pip_issue_ctrl
  import pip_isa_pkg::*;
#(
  parameter int WB_LAT = 5,
  parameter int NREG   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        issue_valid,
  output logic [31:0] issue_instr,
  output logic        stall,
  output logic        busy
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stalls
`endif
);

  // Counter value on the issue edge so the dependent's issue_valid lands WB_LAT cycles later.
  localparam logic [FIELD_W-1:0] SB_LOAD = FIELD_W'(WB_LAT - 1);

  issue_state_t       state_reg;
  logic [31:0]        hold_reg;
  logic               hold_valid;
  logic [FIELD_W-1:0] hold_op;
  logic [FIELD_W-1:0] hold_rd;
  logic [FIELD_W-1:0] hold_rs1;
  logic [FIELD_W-1:0] hold_rs2;
  logic               rs1_busy;
  logic               rs2_busy;
  logic               sb_busy;
  logic               hazard;
  logic               can_issue;
  logic               accept;

  assign hold_valid = (state_reg == ST_HELD);
  assign hold_op    = hold_reg[OPC_LSB +: FIELD_W];
  assign hold_rd    = hold_reg[RD_LSB  +: FIELD_W];
  assign hold_rs1   = hold_reg[RS1_LSB +: FIELD_W];
  assign hold_rs2   = hold_reg[RS2_LSB +: FIELD_W];

  assign hazard    = hold_valid & ((uses_rs1(hold_op) & rs1_busy) |
                                   (uses_rs2(hold_op) & rs2_busy));
  assign can_issue = hold_valid & ~hazard & ~flush;
  assign in_ready  = ~hold_valid | can_issue | flush;
  assign accept    = in_valid & in_ready & ~flush;
  assign stall     = hazard;
  assign busy      = hold_valid | sb_busy;

  pip_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .load_en  (can_issue),
    .load_rd  (hold_rd),
    .load_val (SB_LOAD),
    .rs1      (hold_rs1),
    .rs2      (hold_rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .any_busy (sb_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_EMPTY;
      hold_reg    <= '0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
    end else begin
      issue_valid <= can_issue;
      issue_instr <= can_issue ? hold_reg : 32'h0;
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_reg <= ST_HELD;
            hold_reg  <= in_instr;
          end
        end
        ST_HELD: begin
          if (flush) begin
            state_reg <= ST_EMPTY;
          end else if (can_issue) begin
            // Issue and refill on the same edge keeps the stream back-to-back.
            if (accept) begin
              hold_reg <= in_instr;
            end else begin
              state_reg <= ST_EMPTY;
            end
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

`ifdef ISSUE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued <= '0;
      perf_stalls <= '0;
    end else begin
      if (can_issue) perf_issued <= perf_issued + 32'd1;
      if (hazard)    perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pip_issue_ctrl.sv
// Randomized bench for pip_issue_ctrl against a register-ready-time reference model.
module tb_pip_issue_ctrl;

  localparam int WB_LAT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        flush = 1'b0;
  logic        in_ready;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic        stall;
  logic        busy;
`ifdef ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stalls;
`endif

  pip_issue_ctrl #(
    .WB_LAT (WB_LAT),
    .NREG   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .stall       (stall),
    .busy        (busy)
`ifdef ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: each register remembers the first cycle a consumer may show issue_valid.
  int          cyc = 0;
  int          ready_at [16];
  bit          m_hv = 0;
  logic [31:0] m_hold = 32'h0;
  bit          m_hold_flag = 0;
  bit          m_iv = 0;
  logic [31:0] m_ii = 32'h0;
  int          stall_run = 0;
  logic [31:0] m_perf_iss = 32'h0;
  logic [31:0] m_perf_stl = 32'h0;

  // Source-side driver state.
  bit          pend = 0;
  logic [31:0] pend_instr = 32'h0;
  bit          pend_flag = 0;

  typedef struct {
    bit          v;
    logic [31:0] instr;
    bit          fl;
  } dir_t;
  dir_t dq[$];

  function automatic bit reads_a(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op == 4'h3);
  endfunction

  function automatic bit reads_b(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2);
  endfunction

  function automatic bit blocked(input int r);
    return (cyc + 1) < ready_at[r];
  endfunction

  function automatic bit m_hazard();
    logic [3:0] op, a, b;
    op = m_hold[31:28];
    a  = m_hold[23:20];
    b  = m_hold[19:16];
    return m_hv && ((reads_a(op) && blocked(int'(a))) || (reads_b(op) && blocked(int'(b))));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [3:0] op, rd, a, b;
    int sel;
    sel = int'($urandom_range(0, 5));
    if (sel <= 3)      op = 4'(sel);
    else if (sel == 4) op = 4'hF;
    else               op = 4'($urandom_range(4, 14));
    rd = 4'($urandom_range(0, 5));
    a  = 4'($urandom_range(0, 5));
    b  = 4'($urandom_range(0, 5));
    return {op, rd, a, b, 16'($urandom)};
  endfunction

  task automatic push(input logic [31:0] instr, input bit fl, input int idle);
    dir_t e;
    e.v = 1; e.instr = instr; e.fl = fl;
    dq.push_back(e);
    for (int k = 0; k < idle; k++) begin
      e.v = 0; e.instr = 32'h0; e.fl = 0;
      dq.push_back(e);
    end
  endtask

  task automatic step(input bit rnd);
    bit   hz, can, exp_rdy, exp_busy, acc;
    dir_t e;
    @(negedge clk);
    hz = m_hazard();
    if (!pend) begin
      if (!rnd) begin
        if (dq.size() > 0) begin
          e = dq.pop_front();
          if (e.v) begin
            pend = 1; pend_instr = e.instr; pend_flag = e.fl;
          end
        end
      end else if ($urandom_range(0, 9) < 7) begin
        pend = 1; pend_instr = rand_instr(); pend_flag = 0;
      end
    end
    if (rnd) flush = ($urandom_range(0, 19) == 0);
    else     flush = m_hold_flag && hz && (stall_run == 1);
    in_valid = pend;
    in_instr = pend ? pend_instr : $urandom();
    #1;
    can      = m_hv && !hz && !flush;
    exp_rdy  = !m_hv || can || flush;
    exp_busy = m_hv;
    for (int r = 0; r < 16; r++) if (blocked(r)) exp_busy = 1;
    check_eq("issue_valid", 32'(issue_valid), 32'(m_iv));
    check_eq("issue_instr", issue_instr, m_ii);
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("stall", 32'(stall), 32'(hz));
    check_eq("busy", 32'(busy), 32'(exp_busy));
`ifdef ISSUE_PERF_EN
    check_eq("perf_issued", perf_issued, m_perf_iss);
    check_eq("perf_stalls", perf_stalls, m_perf_stl);
`endif
    if (m_iv) $display("cyc %0d issue %h", cyc, m_ii);
    acc = in_valid && exp_rdy && !flush;
    @(posedge clk);
    if (can) ready_at[int'(m_hold[27:24])] = cyc + 1 + WB_LAT;
    stall_run  = hz ? stall_run + 1 : 0;
    m_perf_iss = m_perf_iss + 32'(can);
    m_perf_stl = m_perf_stl + 32'(hz);
    m_iv = can;
    m_ii = can ? m_hold : 32'h0;
    if (flush) begin
      m_hv = 0;
    end else if (acc) begin
      m_hv = 1; m_hold = in_instr; m_hold_flag = pend_flag;
    end else if (can) begin
      m_hv = 0;
    end
    if (acc) pend = 0;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_issue_valid"}, 32'(issue_valid), 32'h0);
    check_eq({tag, "_issue_instr"}, issue_instr, 32'h0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    check_eq({tag, "_stall"}, 32'(stall), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
`ifdef ISSUE_PERF_EN
    check_eq({tag, "_perf_issued"}, perf_issued, 32'h0);
    check_eq({tag, "_perf_stalls"}, perf_stalls, 32'h0);
`endif
  endtask

  initial begin
    int n;
    for (int r = 0; r < 16; r++) ready_at[r] = 0;

    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Directed scenarios, each followed by idle cycles to drain.
    push(32'h1123_0000, 0, 0); push(32'h1456_0000, 0, 8);
    push(32'h1123_0000, 0, 0); push(32'h2415_0000, 0, 8);
    push(32'h3720_0000, 0, 0); push(32'h1897_0000, 0, 8);
    push(32'h3720_0000, 0, 0); push(32'h3890_0000, 0, 8);
    push(32'hF100_0000, 0, 0); push(32'h1512_0000, 0, 8);
    push(32'hF100_0000, 0, 0); push(32'h0011_0000, 0, 8);
    push(32'h1123_0000, 0, 0); push(32'h2415_0000, 1, 8);
    n = 0;
    while ((dq.size() > 0 || pend) && n < 400) begin
      step(0);
      n++;
    end
    check_eq("directed_drain", 32'(dq.size() > 0 || pend), 32'h0);
    for (int k = 0; k < 10; k++) step(0);

    for (int k = 0; k < 1500; k++) step(1);
    flush = 1'b0;
    for (int k = 0; k < 20; k++) step(0);

    // Asynchronous reset while a dependent is stalled.
    push(32'h1123_0000, 0, 0); push(32'h2415_0000, 0, 0);
    n = 0;
    while (!m_hazard() && n < 20) begin
      step(0);
      n++;
    end
    check_eq("reach_stall", 32'(m_hazard()), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    m_hv = 0; m_iv = 0; m_ii = 32'h0; pend = 0; stall_run = 0; m_hold_flag = 0;
    m_perf_iss = 32'h0; m_perf_stl = 32'h0;
    for (int r = 0; r < 16; r++) ready_at[r] = 0;
    dq.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) step(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
